// File: rtl/core_ctrl_pkg.sv
// Shared types for the core sequencing controller.
package core_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_COMP  = 3'd2,
    ST_OVLP  = 3'd3,
    ST_DRAIN = 3'd4,
    ST_FIN   = 3'd5
  } core_seq_state_t;

endpackage

// File: rtl/core_seq_ctrl.sv
// Task sequencer: walks tiles through load, compute and zout, overlapping
// the zout of tile i with the load of tile i+1.
module core_seq_ctrl #(
  parameter int TILE_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [TILE_W-1:0] cfg_tile_num,
  input  logic [7:0]        cfg_store_depth,
  input  logic [4:0]        cfg_store_tapu_depth,
  output logic              load_start,
  output logic              comp_start,
  output logic              zout_start,
  input  logic              load_done,
  input  logic              comp_done,
  input  logic              zout_done,
  output logic [7:0]        store_depth,
  output logic [4:0]        store_tapu_depth,
  output logic [TILE_W-1:0] tile_idx,
  output logic              busy,
  output logic              task_done
);
  import core_ctrl_pkg::*;

  core_seq_state_t   r_state;
  core_seq_state_t   w_state_next;
  logic [TILE_W-1:0] r_tile_num;
  logic [TILE_W-1:0] r_tile_idx;
  logic [TILE_W-1:0] w_tile_idx_next;
  logic [7:0]        r_store_depth;
  logic [4:0]        r_store_tapu_depth;
  logic              r_load_seen;
  logic              r_zout_seen;
  logic              w_load_seen_next;
  logic              w_zout_seen_next;
  logic              r_load_start;
  logic              r_comp_start;
  logic              r_zout_start;
  logic              r_task_done;
  logic              w_accept;
  logic              w_enter;
  logic              w_load_any;
  logic              w_zout_any;

  assign w_accept   = (r_state == ST_IDLE) && cfg_valid;
  // A done counts in OVLP whether it was captured earlier or is live now.
  assign w_load_any = r_load_seen | load_done;
  assign w_zout_any = r_zout_seen | zout_done;

  always_comb begin
    w_state_next     = r_state;
    w_tile_idx_next  = r_tile_idx;
    w_load_seen_next = 1'b0;
    w_zout_seen_next = 1'b0;
    case (r_state)
      ST_IDLE:  if (cfg_valid) w_state_next = ST_LOAD;
      ST_LOAD:  if (load_done) w_state_next = ST_COMP;
      ST_COMP: begin
        if (comp_done) begin
          w_state_next = (r_tile_idx != r_tile_num) ? ST_OVLP : ST_DRAIN;
        end
      end
      ST_OVLP: begin
        if (w_load_any && w_zout_any) begin
          w_state_next    = ST_COMP;
          w_tile_idx_next = r_tile_idx + TILE_W'(1);
        end else begin
          w_load_seen_next = w_load_any;
          w_zout_seen_next = w_zout_any;
        end
      end
      ST_DRAIN: if (zout_done) w_state_next = ST_FIN;
      ST_FIN: begin
        w_state_next    = ST_IDLE;
        w_tile_idx_next = '0;
      end
      default: begin
        w_state_next    = ST_IDLE;
        w_tile_idx_next = '0;
      end
    endcase
  end

  // No state loops onto itself, so a state change marks a state entry.
  assign w_enter = (w_state_next != r_state);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state            <= ST_IDLE;
      r_tile_num         <= '0;
      r_tile_idx         <= '0;
      r_store_depth      <= '0;
      r_store_tapu_depth <= '0;
      r_load_seen        <= 1'b0;
      r_zout_seen        <= 1'b0;
      r_load_start       <= 1'b0;
      r_comp_start       <= 1'b0;
      r_zout_start       <= 1'b0;
      r_task_done        <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_tile_idx   <= w_tile_idx_next;
      r_load_seen  <= w_load_seen_next;
      r_zout_seen  <= w_zout_seen_next;
      r_load_start <= w_enter && ((w_state_next == ST_LOAD) || (w_state_next == ST_OVLP));
      r_comp_start <= w_enter && (w_state_next == ST_COMP);
      r_zout_start <= w_enter && ((w_state_next == ST_OVLP) || (w_state_next == ST_DRAIN));
      r_task_done  <= w_enter && (w_state_next == ST_FIN);
      if (w_accept) begin
        r_tile_num         <= cfg_tile_num;
        r_store_depth      <= cfg_store_depth;
        r_store_tapu_depth <= cfg_store_tapu_depth;
      end
    end
  end

  assign cfg_ready        = (r_state == ST_IDLE);
  assign busy             = (r_state != ST_IDLE);
  assign load_start       = r_load_start;
  assign comp_start       = r_comp_start;
  assign zout_start       = r_zout_start;
  assign task_done        = r_task_done;
  assign tile_idx         = r_tile_idx;
  assign store_depth      = r_store_depth;
  assign store_tapu_depth = r_store_tapu_depth;

endmodule

// File: tb/tb_core_seq_ctrl.sv
// Directed bench for core_seq_ctrl: single-tile, multi-tile, overlap
// ordering, spurious dones, held-off config and mid-task reset.
module tb_core_seq_ctrl;
  localparam int TILE_W = 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              cfg_valid;
  logic              cfg_ready;
  logic [TILE_W-1:0] cfg_tile_num;
  logic [7:0]        cfg_store_depth;
  logic [4:0]        cfg_store_tapu_depth;
  logic              load_start, comp_start, zout_start;
  logic              load_done, comp_done, zout_done;
  logic [7:0]        store_depth;
  logic [4:0]        store_tapu_depth;
  logic [TILE_W-1:0] tile_idx;
  logic              busy, task_done;

  int n_checks = 0;
  int n_pass   = 0;
  int n_load = 0, n_comp = 0, n_zout = 0, n_ovlp = 0;
  int s_load, s_comp, s_zout, s_ovlp;

  core_seq_ctrl #(.TILE_W(TILE_W)) dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .cfg_valid            (cfg_valid),
    .cfg_ready            (cfg_ready),
    .cfg_tile_num         (cfg_tile_num),
    .cfg_store_depth      (cfg_store_depth),
    .cfg_store_tapu_depth (cfg_store_tapu_depth),
    .load_start           (load_start),
    .comp_start           (comp_start),
    .zout_start           (zout_start),
    .load_done            (load_done),
    .comp_done            (comp_done),
    .zout_done            (zout_done),
    .store_depth          (store_depth),
    .store_tapu_depth     (store_tapu_depth),
    .tile_idx             (tile_idx),
    .busy                 (busy),
    .task_done            (task_done)
  );

  always #5 clk = ~clk;

  // Start pulse tallies; a same-cycle load+zout start marks an OVLP entry.
  always @(negedge clk) begin
    if (load_start) n_load++;
    if (comp_start) n_comp++;
    if (zout_start) n_zout++;
    if (load_start && zout_start) n_ovlp++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // 1=load, 2=comp, 4=zout; bits combine for same-cycle dones.
  task automatic done(input int mask);
    load_done = mask[0];
    comp_done = mask[1];
    zout_done = mask[2];
    step();
    load_done = 1'b0;
    comp_done = 1'b0;
    zout_done = 1'b0;
  endtask

  task automatic snap();
    s_load = n_load; s_comp = n_comp; s_zout = n_zout; s_ovlp = n_ovlp;
  endtask

  initial begin
    rst_n = 1'b0; cfg_valid = 1'b0; cfg_tile_num = '0;
    cfg_store_depth = '0; cfg_store_tapu_depth = '0;
    load_done = 1'b0; comp_done = 1'b0; zout_done = 1'b0;
    step(); step();
    rst_n = 1'b1;
    check("rst_busy", busy, 0);
    check("rst_ready", cfg_ready, 1);
    check("rst_idx", tile_idx, 0);
    check("rst_depth", store_depth, 0);
    check("rst_tapu", store_tapu_depth, 0);
    check("rst_pulses", {load_start, comp_start, zout_start, task_done}, 0);
    $display("txn reset done");

    // Single tile: LOAD -> COMP -> DRAIN -> FIN
    cfg_valid = 1'b1; cfg_tile_num = 8'd0; cfg_store_depth = 8'd3; cfg_store_tapu_depth = 5'd5;
    step();
    cfg_valid = 1'b0;
    check("t1_load_start", load_start, 1);
    check("t1_busy", busy, 1);
    check("t1_ready", cfg_ready, 0);
    check("t1_depth", store_depth, 3);
    check("t1_tapu", store_tapu_depth, 5);
    step();
    check("t1_load_1cyc", load_start, 0);
    done(1);
    check("t1_comp_start", {load_start, comp_start, zout_start}, 3'b010);
    done(2);
    check("t1_drain_zout_only", {load_start, comp_start, zout_start}, 3'b001);
    step();
    check("t1_zout_1cyc", zout_start, 0);
    done(4);
    check("t1_task_done", task_done, 1);
    check("t1_fin_busy", busy, 1);
    step();
    check("t1_task_done_1cyc", task_done, 0);
    check("t1_idle_busy", busy, 0);
    check("t1_idle_ready", cfg_ready, 1);
    $display("txn single-tile task complete");

    // Three tiles; overlap orders zout-first then load-first
    snap();
    cfg_valid = 1'b1; cfg_tile_num = 8'd2; cfg_store_depth = 8'h21; cfg_store_tapu_depth = 5'd9;
    step();
    cfg_valid = 1'b0;
    done(1);
    check("t2_idx0", tile_idx, 0);
    done(2);
    check("t2_ovlp0_starts", {load_start, zout_start}, 2'b11);
    done(4);
    for (int i = 0; i < 4; i++) begin
      check("t2_a_wait", comp_start, 0);
      step();
    end
    done(1);
    check("t2_a_comp_start", comp_start, 1);
    check("t2_idx1", tile_idx, 1);
    done(2);
    done(1);
    for (int i = 0; i < 4; i++) begin
      check("t2_b_wait", comp_start, 0);
      step();
    end
    done(4);
    check("t2_b_comp_start", comp_start, 1);
    check("t2_idx2", tile_idx, 2);
    done(2);
    check("t2_drain", {load_start, zout_start}, 2'b01);
    check("t2_idx_hold", tile_idx, 2);
    done(4);
    check("t2_task_done", task_done, 1);
    step();
    check("t2_idx_back0", tile_idx, 0);
    check("t2_n_load", n_load - s_load, 3);
    check("t2_n_comp", n_comp - s_comp, 3);
    check("t2_n_zout", n_zout - s_zout, 3);
    check("t2_n_ovlp", n_ovlp - s_ovlp, 2);
    $display("txn three-tile task complete");

    // Two tiles with cfg_valid held; spurious dones; same-cycle overlap dones
    snap();
    cfg_valid = 1'b1; cfg_tile_num = 8'd1; cfg_store_depth = 8'h44; cfg_store_tapu_depth = 5'd2;
    step();
    cfg_tile_num = 8'd0; cfg_store_depth = 8'h99; cfg_store_tapu_depth = 5'd7;
    step();
    done(2);
    check("t3_spur_comp", {load_start, comp_start, zout_start}, 0);
    check("t3_spur_busy", busy, 1);
    done(1);
    check("t3_comp_start", comp_start, 1);
    done(4);
    check("t3_spur_zout", {load_start, comp_start, zout_start}, 0);
    check("t3_held_ready", cfg_ready, 0);
    done(2);
    check("t3_ovlp_starts", {load_start, zout_start}, 2'b11);
    done(5);
    check("t3_same_cyc_comp", comp_start, 1);
    check("t3_idx1", tile_idx, 1);
    check("t3_depth_held", store_depth, 8'h44);
    done(2);
    done(4);
    check("t3_task_done", task_done, 1);
    check("t3_fin_ready", cfg_ready, 0);
    check("t3_fin_depth", store_depth, 8'h44);
    step();
    check("t3_idle_ready", cfg_ready, 1);
    check("t3_idle_depth", store_depth, 8'h44);
    check("t3_n_comp", n_comp - s_comp, 2);
    step();
    cfg_valid = 1'b0;
    check("t4_accept", load_start, 1);
    check("t4_depth", store_depth, 8'h99);
    check("t4_tapu", store_tapu_depth, 7);
    done(1);
    done(2);
    check("t4_drain_no_ovlp", {load_start, zout_start}, 2'b01);
    done(4);
    check("t4_task_done", task_done, 1);
    step();
    $display("txn held-config tasks complete");

    // Reset while in OVLP with a captured zout_done
    cfg_valid = 1'b1; cfg_tile_num = 8'd3; cfg_store_depth = 8'h10; cfg_store_tapu_depth = 5'd1;
    step();
    cfg_valid = 1'b0;
    done(1);
    done(2);
    done(4);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("r_busy", busy, 0);
    check("r_idx", tile_idx, 0);
    check("r_ready", cfg_ready, 1);
    check("r_pulses", {load_start, comp_start, zout_start, task_done}, 0);
    check("r_depth", store_depth, 0);
    step();
    check("r_pulses2", {load_start, comp_start, zout_start, task_done}, 0);
    cfg_valid = 1'b1; cfg_tile_num = 8'd1; cfg_store_depth = 8'h05; cfg_store_tapu_depth = 5'd3;
    step();
    cfg_valid = 1'b0;
    done(1);
    done(2);
    done(1);
    check("r_flag_cleared", comp_start, 0);
    done(4);
    check("r_ovlp_exit", comp_start, 1);
    check("r_idx1", tile_idx, 1);
    $display("txn mid-task reset complete");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/core_seq_ctrl.md
CORE_SEQ_CTRL -- requirements
Module: core_seq_ctrl

Interface
REQ-001 SHALL have parameter TILE_W, default 8, giving the width of the tile count and tile index.
REQ-002 SHALL have port clk, input, 1, clock; all logic on rising edge.
REQ-003 SHALL have port rst_n, input, 1, reset: synchronous, active-low.
REQ-004 SHALL have port cfg_valid, input, 1, task descriptor valid.
REQ-005 SHALL have port cfg_ready, output, 1, descriptor accepted when high with cfg_valid.
REQ-006 SHALL have port cfg_tile_num, input, TILE_W, number of tiles minus 1.
REQ-007 SHALL have port cfg_store_depth, input, 8, zout store count minus 1.
REQ-008 SHALL have port cfg_store_tapu_depth, input, 5, per-TAPU store count minus 1.
REQ-009 SHALL have ports load_start / comp_start / zout_start, output, 1 each, single-cycle start pulses to the load, compute and zout units.
REQ-010 SHALL have ports load_done / comp_done / zout_done, input, 1 each, single-cycle completion pulses from those units.
REQ-011 SHALL have ports store_depth (output, 8) and store_tapu_depth (output, 5), the latched config driven to the zout unit.
REQ-012 SHALL have port tile_idx, output, TILE_W, index of the tile currently computing.
REQ-013 SHALL have ports busy (output, 1), high when not IDLE, and task_done (output, 1), a single-cycle pulse at task end.

Function
REQ-014 SHALL implement FSM states IDLE, LOAD, COMP, OVLP (zout of tile i overlapped with load of tile i+1), DRAIN (zout of last tile) and FIN.
REQ-015 SHALL drive cfg_ready=1 only in IDLE; on accept, latch all cfg_* fields and move to LOAD.
REQ-016 SHALL hold store_depth and store_tapu_depth stable from accept until the next accept.
REQ-017 SHALL register all start pulses: each is high exactly for the first cycle of its owning state/phase, never longer than 1 cycle.
REQ-018 LOAD: load_start on entry; on load_done -> COMP.
REQ-019 COMP: comp_start on entry; on comp_done -> OVLP if tile_idx != tile_num, else DRAIN.
REQ-020 OVLP: zout_start and load_start both pulse on entry (same cycle).
REQ-021 OVLP: load_done and zout_done SHALL be captured in sticky flags, accepting either order or the same cycle.
REQ-022 OVLP: in the cycle both are seen (flag or live input), -> COMP, tile_idx+1, flags cleared.
REQ-023 DRAIN: zout_start on entry; on zout_done -> FIN.
REQ-024 FIN: task_done=1 for one cycle, then IDLE; tile_idx returns to 0 on exit.
REQ-025 SHALL ignore done pulses arriving in states not waiting for them (no flag set, no transition).
REQ-026 cfg_tile_num=0 SHALL give LOAD->COMP->DRAIN->FIN, with no OVLP.
REQ-027 tile_idx SHALL never exceed latched tile_num; no wrap occurs within a task.
REQ-028 cfg_valid while busy SHALL be held off (cfg_ready=0), with no loss or corruption of the current task.

Reset
REQ-029 On rst_n=0: state IDLE, all start pulses 0, task_done 0, busy 0, tile_idx 0, store_depth 0, store_tapu_depth 0, sticky flags 0, cfg_ready 1 from the first cycle after release.
REQ-030 Reset mid-task SHALL abort immediately, with no pulse in the first cycle after release.

Structure
REQ-031 SHALL place the state enum typedef (core_seq_state_t) in shared package core_ctrl_pkg.
REQ-032 SHALL be a single flat module with no sub-module; the pulse registers and sticky flags are inline.

Verification
REQ-033 tile_num=0, store_depth=3: accept -> load_start; load_done -> comp_start; comp_done -> zout_start only; zout_done -> task_done 1 cycle, busy low next cycle.
REQ-034 tile_num=2: tile_idx steps 0,1,2; load_start count 3, comp_start 3, zout_start 3; OVLP entered twice.
REQ-035 OVLP with zout_done 5 cycles before load_done, then reversed, then same cycle: comp_start exactly once each, 1 cycle after the later done.
REQ-036 Spurious comp_done in LOAD and zout_done in COMP: no state change, no extra pulse.
REQ-037 cfg_valid held through a 2-tile task: second descriptor accepted only in IDLE after task_done; store_depth unchanged until then.
REQ-038 rst_n low for 1 cycle while in OVLP: next cycle IDLE, tile_idx 0, no start pulses, cfg_ready 1.
